// File: rtl/issue_alloc_unit.sv
// Issue/allocation stage: hands out one ROB slot and one RS entry per accepted
// instruction and tracks ROB head/tail/occupancy and RS busy bits internally.
module issue_alloc_unit #(
   parameter int ROB_DEPTH = 8,
   parameter int N_LS      = 6,
   parameter int N_ADD     = 3,
   parameter int N_MUL     = 2,
   localparam int RW       = $clog2(ROB_DEPTH),
   localparam int N_RS     = N_LS + N_ADD + N_MUL,
   localparam int SW       = $clog2(N_RS + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            inst_valid,
   input  logic [2:0]      inst_op,
   output logic            inst_ready,
   output logic            struct_haz,
   input  logic            commit_valid,
   input  logic [N_RS-1:0] rs_release,
   output logic            issue_valid,
   output logic [RW-1:0]   issue_rob_idx,
   output logic [SW-1:0]   issue_rs_idx,
   output logic [RW:0]     rob_count,
   output logic [RW-1:0]   rob_head,
   output logic [31:0]     issue_cnt
);

   // Handshake: an instruction transfers on a cycle where inst_valid and
   // inst_ready are both high; inst_ready never looks at inst_valid.

   logic [RW-1:0]   tail_q;
   logic [N_RS-1:0] busy_q;
   logic [N_RS-1:0] cls_mask;
   logic [N_RS-1:0] free_vec;
   logic [N_RS-1:0] alloc_mask;
   logic [SW-1:0]   pick_idx;
   logic            pick_found;
   logic            is_ls, is_add, is_mul, legal;
   logic            rob_full, fire, legal_fire, commit_eff;

   assign is_ls  = (inst_op == 3'd4) || (inst_op == 3'd5);
   assign is_add = (inst_op == 3'd0) || (inst_op == 3'd1);
   assign is_mul = (inst_op == 3'd2) || (inst_op == 3'd3);
   assign legal  = is_ls | is_add | is_mul;

   always_comb begin
      cls_mask = '0;
      for (int i = 0; i < N_RS; i++) begin
         if (i < N_LS)              cls_mask[i] = is_ls;
         else if (i < N_LS + N_ADD) cls_mask[i] = is_add;
         else                       cls_mask[i] = is_mul;
      end
   end

   assign free_vec = ~busy_q & cls_mask;

   // Descending scan so the lowest free index in the class wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = SW'(N_RS);
      for (int i = N_RS - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            pick_found = 1'b1;
            pick_idx   = SW'(i);
         end
      end
   end

   assign rob_full   = (rob_count == (RW+1)'(ROB_DEPTH));
   assign inst_ready = ~flush & (~legal | (~rob_full & pick_found));
   assign struct_haz = inst_valid & ~inst_ready & ~flush;
   assign fire       = inst_valid & inst_ready;
   assign legal_fire = fire & legal;
   assign commit_eff = commit_valid & (rob_count != '0);
   assign alloc_mask = legal_fire ? ({{(N_RS-1){1'b0}}, 1'b1} << pick_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rob_head      <= '0;
         tail_q        <= '0;
         rob_count     <= '0;
         busy_q        <= '0;
         issue_valid   <= 1'b0;
         issue_rob_idx <= '0;
         issue_rs_idx  <= SW'(N_RS);
         issue_cnt     <= '0;
      end else if (flush) begin
         rob_head    <= '0;
         tail_q      <= '0;
         rob_count   <= '0;
         busy_q      <= '0;
         issue_valid <= 1'b0;
         issue_cnt   <= '0;
      end else begin
         busy_q <= (busy_q & ~rs_release) | alloc_mask;
         if (commit_eff) rob_head <= rob_head + RW'(1);
         if (legal_fire) begin
            tail_q    <= tail_q + RW'(1);
            issue_cnt <= issue_cnt + 32'd1;
         end
         case ({legal_fire, commit_eff})
            2'b10:   rob_count <= rob_count + (RW+1)'(1);
            2'b01:   rob_count <= rob_count - (RW+1)'(1);
            default: rob_count <= rob_count;
         endcase
         issue_valid <= legal_fire;
         if (legal_fire) begin
            issue_rob_idx <= tail_q;
            issue_rs_idx  <= pick_idx;
         end else if (fire) begin
            issue_rs_idx  <= SW'(N_RS);
         end
      end
   end

endmodule

// File: tb/tb_issue_alloc_unit.sv
// Directed table-driven bench for issue_alloc_unit with default parameters
// (ROB 8, RS split 6/3/2, garbage RS index 11).
module tb_issue_alloc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        inst_valid;
   logic [2:0]  inst_op;
   logic        inst_ready;
   logic        struct_haz;
   logic        commit_valid;
   logic [10:0] rs_release;
   logic        issue_valid;
   logic [2:0]  issue_rob_idx;
   logic [3:0]  issue_rs_idx;
   logic [3:0]  rob_count;
   logic [2:0]  rob_head;
   logic [31:0] issue_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   issue_alloc_unit dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .inst_valid(inst_valid), .inst_op(inst_op),
      .inst_ready(inst_ready), .struct_haz(struct_haz),
      .commit_valid(commit_valid), .rs_release(rs_release),
      .issue_valid(issue_valid), .issue_rob_idx(issue_rob_idx),
      .issue_rs_idx(issue_rs_idx), .rob_count(rob_count),
      .rob_head(rob_head), .issue_cnt(issue_cnt)
   );

   typedef struct {
      logic        v;
      logic [2:0]  op;
      logic        cm;
      logic [10:0] rel;
      logic        fl;
      logic        rdy;
      logic        haz;
      logic        iv;
      logic [2:0]  rob;
      logic [3:0]  rs;
      logic [3:0]  cnt;
      logic [2:0]  head;
      logic [31:0] icnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [2:0] op, input logic cm,
                      input logic [10:0] rel, input logic fl,
                      input logic rdy, input logic haz, input logic iv,
                      input logic [2:0] rob, input logic [3:0] rs,
                      input logic [3:0] cnt, input logic [2:0] head,
                      input logic [31:0] icnt);
      vec_t t;
      t.v = v; t.op = op; t.cm = cm; t.rel = rel; t.fl = fl;
      t.rdy = rdy; t.haz = haz; t.iv = iv; t.rob = rob; t.rs = rs;
      t.cnt = cnt; t.head = head; t.icnt = icnt;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, n, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t t, input int n);
      @(negedge clk);
      inst_valid   = t.v;
      inst_op      = t.op;
      commit_valid = t.cm;
      rs_release   = t.rel;
      flush        = t.fl;
      #1;
      chk("inst_ready", n, 32'(inst_ready), 32'(t.rdy));
      chk("struct_haz", n, 32'(struct_haz), 32'(t.haz));
      @(posedge clk);
      #1;
      chk("issue_valid", n, 32'(issue_valid), 32'(t.iv));
      chk("issue_rob_idx", n, 32'(issue_rob_idx), 32'(t.rob));
      chk("issue_rs_idx", n, 32'(issue_rs_idx), 32'(t.rs));
      chk("rob_count", n, 32'(rob_count), 32'(t.cnt));
      chk("rob_head", n, 32'(rob_head), 32'(t.head));
      chk("issue_cnt", n, issue_cnt, t.icnt);
   endtask

   initial begin
      // Columns: v op cm rel fl | rdy haz | iv rob rs cnt head icnt
      // ADD, ADD, MUL, LOAD back to back
      add(1, 0, 0, 11'h000, 0, 1, 0, 1, 0,  6, 1, 0, 1);
      add(1, 0, 0, 11'h000, 0, 1, 0, 1, 1,  7, 2, 0, 2);
      add(1, 2, 0, 11'h000, 0, 1, 0, 1, 2,  9, 3, 0, 3);
      add(1, 4, 0, 11'h000, 0, 1, 0, 1, 3,  0, 4, 0, 4);
      // ADD class exhausted; release of rs7 only usable a cycle later
      add(1, 1, 0, 11'h000, 0, 1, 0, 1, 4,  8, 5, 0, 5);
      add(1, 0, 0, 11'h000, 0, 0, 1, 0, 4,  8, 5, 0, 5);
      add(1, 0, 0, 11'h080, 0, 0, 1, 0, 4,  8, 5, 0, 5);
      add(1, 0, 0, 11'h000, 0, 1, 0, 1, 5,  7, 6, 0, 6);
      // fill the ROB
      add(1, 4, 0, 11'h000, 0, 1, 0, 1, 6,  1, 7, 0, 7);
      add(1, 5, 0, 11'h000, 0, 1, 0, 1, 7,  2, 8, 0, 8);
      // illegal op accepted even with the ROB full
      add(1, 6, 0, 11'h000, 0, 1, 0, 0, 7, 11, 8, 0, 8);
      add(1, 4, 0, 11'h000, 0, 0, 1, 0, 7, 11, 8, 0, 8);
      // commit on a full ROB does not let the waiting LOAD through
      add(1, 4, 1, 11'h000, 0, 0, 1, 0, 7, 11, 7, 1, 8);
      add(1, 4, 0, 11'h000, 0, 1, 0, 1, 0,  3, 8, 1, 9);
      // drain to count 3
      add(0, 4, 1, 11'h000, 0, 0, 0, 0, 0,  3, 7, 2, 9);
      add(0, 4, 1, 11'h000, 0, 1, 0, 0, 0,  3, 6, 3, 9);
      add(0, 4, 1, 11'h000, 0, 1, 0, 0, 0,  3, 5, 4, 9);
      add(0, 4, 1, 11'h000, 0, 1, 0, 0, 0,  3, 4, 5, 9);
      add(0, 4, 1, 11'h000, 0, 1, 0, 0, 0,  3, 3, 6, 9);
      // commit plus DIV fire: count holds, head and tail advance
      add(1, 3, 1, 11'h000, 0, 1, 0, 1, 1, 10, 3, 7, 10);
      // opcode 7
      add(1, 7, 0, 11'h000, 0, 1, 0, 0, 1, 11, 3, 7, 10);
      // release LS 0..3, leaving 5 RS entries busy
      add(0, 0, 0, 11'h00F, 0, 0, 0, 0, 1, 11, 3, 7, 10);
      // flush alongside a valid ADD
      add(1, 0, 0, 11'h000, 1, 0, 0, 0, 1, 11, 0, 0, 0);
      add(1, 0, 0, 11'h000, 0, 1, 0, 1, 0,  6, 1, 0, 1);
      // commit, then commit on an empty ROB is ignored
      add(0, 0, 1, 11'h000, 0, 1, 0, 0, 0,  6, 0, 1, 1);
      add(0, 0, 1, 11'h000, 0, 1, 0, 0, 0,  6, 0, 1, 1);
      // release of rs6 (and non-busy rs9) in the allocating cycle
      add(1, 0, 0, 11'h240, 0, 1, 0, 1, 1,  7, 1, 1, 2);
      add(1, 0, 0, 11'h000, 0, 1, 0, 1, 2,  6, 2, 1, 3);

      rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; inst_op = 3'd0;
      commit_valid = 1'b0; rs_release = '0;
      #12;
      chk("rst_issue_valid", -1, 32'(issue_valid), 32'd0);
      chk("rst_issue_rob_idx", -1, 32'(issue_rob_idx), 32'd0);
      chk("rst_issue_rs_idx", -1, 32'(issue_rs_idx), 32'd11);
      chk("rst_rob_count", -1, 32'(rob_count), 32'd0);
      chk("rst_rob_head", -1, 32'(rob_head), 32'd0);
      chk("rst_issue_cnt", -1, issue_cnt, 32'd0);
      chk("rst_inst_ready", -1, 32'(inst_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // asynchronous reset in the middle of a cycle
      @(negedge clk);
      inst_valid = 1'b0; commit_valid = 1'b0; rs_release = '0; flush = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_issue_valid", -2, 32'(issue_valid), 32'd0);
      chk("async_issue_rob_idx", -2, 32'(issue_rob_idx), 32'd0);
      chk("async_issue_rs_idx", -2, 32'(issue_rs_idx), 32'd11);
      chk("async_rob_count", -2, 32'(rob_count), 32'd0);
      chk("async_rob_head", -2, 32'(rob_head), 32'd0);
      chk("async_issue_cnt", -2, issue_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
